// File: rtl/dmem_pkg.sv
// Shared constants and FSM state encoding for the data-memory responder.
package dmem_pkg;
  localparam int DWORD_W  = 64;
  localparam int BYTE_OFS = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;
endpackage

// File: rtl/dmem_array.sv
// DEPTH x 64-bit storage: synchronous write, registered synchronous read.
// The read register resets to zero and can be forced to load zero; contents are never reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               i_we,
  input  logic               i_re,
  input  logic               i_rzero,
  input  logic [IDX_W-1:0]   i_idx,
  input  logic [DWORD_W-1:0] i_wdata,
  output logic [DWORD_W-1:0] o_rdata
);

  logic [DWORD_W-1:0] r_mem [DEPTH];
  logic [DWORD_W-1:0] r_rdata;

  always_ff @(posedge clock) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= i_rzero ? '0 : r_mem[i_idx];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the LEGv8 MEM stage (IDLE -> BUSY -> RESP).
// Build option: define DMEM_ALIGN_CHECK_EN to add the misalign output and suppress misaligned accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_read,
  input  logic               req_write,
  input  logic [63:0]        req_addr,
  input  logic [63:0]        req_wdata,
  output logic               stall,
  output logic [63:0]        rdata,
  output logic               rvalid,
`ifdef DMEM_ALIGN_CHECK_EN
  output logic               misalign,
`endif
  output logic [1:0]         dbg_state
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  dmem_state_e          r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic                 r_write, r_load, r_bad;
  logic [IDX_W-1:0]     r_idx;
  logic [DWORD_W-1:0]   r_wdata;
  logic                 r_rvalid;

  logic                 w_req, w_accept, w_access, w_live;
  logic                 w_live_bad;
  logic                 w_acc_write, w_acc_load, w_acc_bad;
  logic [IDX_W-1:0]     w_acc_idx;
  logic [DWORD_W-1:0]   w_acc_wdata;
  logic                 w_unused_addr;

  assign w_req         = req_read | req_write;
  assign w_unused_addr = ^{req_addr[63:BYTE_OFS+IDX_W], req_addr[BYTE_OFS-1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
  assign w_live_bad = |req_addr[BYTE_OFS-1:0];
`else
  assign w_live_bad = 1'b0;
`endif

  // Handshake: a request is held by the pipeline while stall is high; it is
  // accepted on the first IDLE edge and the pipeline advances on the RESP edge.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    stall       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          stall     = 1'b1;
          w_accept  = 1'b1;
          w_cnt_nxt = CNT_INIT;
          if (LATENCY > 1) begin
            w_state_nxt = ST_BUSY;
          end else begin
            w_state_nxt = ST_RESP;
            w_access    = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        stall     = 1'b1;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == CNT_W'(1)) begin
          w_access    = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // With LATENCY==1 the access happens on the accept edge, so use live inputs.
  assign w_live      = (r_state == ST_IDLE);
  assign w_acc_write = w_live ? req_write : r_write;
  assign w_acc_load  = w_live ? (req_read & ~req_write) : r_load;
  assign w_acc_bad   = w_live ? w_live_bad : r_bad;
  assign w_acc_idx   = w_live ? req_addr[BYTE_OFS +: IDX_W] : r_idx;
  assign w_acc_wdata = w_live ? req_wdata : r_wdata;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_write  <= 1'b0;
      r_load   <= 1'b0;
      r_bad    <= 1'b0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rvalid <= w_access & w_acc_load;
      if (w_accept) begin
        r_write <= req_write;
        r_load  <= req_read & ~req_write;
        r_bad   <= w_live_bad;
        r_idx   <= req_addr[BYTE_OFS +: IDX_W];
        r_wdata <= req_wdata;
      end
    end
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic r_misalign;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_access & w_acc_bad;
    end
  end
  assign misalign = r_misalign;
`endif

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clock   (clock),
    .reset_n (reset_n),
    .i_we    (w_access & w_acc_write & ~w_acc_bad),
    .i_re    (w_access & w_acc_load),
    .i_rzero (w_acc_bad),
    .i_idx   (w_acc_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (rdata)
  );

  assign rvalid    = r_rvalid;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: LATENCY=2 and LATENCY=1 instances, directed table,
// hand-written corner sequences and randomized traffic against a memory model.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;

  logic        rd2, wr2, stall2, rvalid2;
  logic [63:0] addr2, wdata2, rdata2;
  logic [1:0]  st2;
  logic        rd1, wr1, stall1, rvalid1;
  logic [63:0] addr1, wdata1, rdata1;
  logic [1:0]  st1;
  logic        mis2, mis1;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] model_mem [256];

  always #5 clock = ~clock;

  dmem_responder #(.DEPTH(256), .LATENCY(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_read(rd2), .req_write(wr2), .req_addr(addr2), .req_wdata(wdata2),
    .stall(stall2), .rdata(rdata2), .rvalid(rvalid2),
`ifdef DMEM_ALIGN_CHECK_EN
    .misalign(mis2),
`endif
    .dbg_state(st2)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(1)) dut1 (
    .clock(clock), .reset_n(reset_n),
    .req_read(rd1), .req_write(wr1), .req_addr(addr1), .req_wdata(wdata1),
    .stall(stall1), .rdata(rdata1), .rvalid(rvalid1),
`ifdef DMEM_ALIGN_CHECK_EN
    .misalign(mis1),
`endif
    .dbg_state(st1)
  );

`ifndef DMEM_ALIGN_CHECK_EN
  assign mis2 = 1'b0;
  assign mis1 = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr,
                       input logic [63:0] a, input logic [63:0] d);
    if (sel == 2) begin
      rd2 = rd; wr2 = wr; addr2 = a; wdata2 = d;
    end else begin
      rd1 = rd; wr1 = wr; addr1 = a; wdata1 = d;
    end
  endtask

  // Present a request from the next falling edge, count stalled cycles, and
  // sample the response in the first cycle with stall low (the request stays held).
  task automatic op(input int sel, input bit rd, input bit wr,
                    input logic [63:0] a, input logic [63:0] d,
                    output int stalls, output bit rv, output logic [63:0] data, output bit mis);
    @(negedge clock);
    drive(sel, rd, wr, a, d);
    #1;
    stalls = 0;
    while (((sel == 2) ? stall2 : stall1) && stalls < 20) begin
      stalls++;
      @(negedge clock);
      #1;
    end
    rv   = (sel == 2) ? rvalid2 : rvalid1;
    data = (sel == 2) ? rdata2  : rdata1;
    mis  = (sel == 2) ? mis2    : mis1;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          exp_stalls;
    bit          exp_rv;
    logic [63:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stalls;
    bit          rv, mis, is_load;
    logic [63:0] data, a, d, expd;
    int          idx;

    reset_n = 1'b0;
    drive(2, 0, 0, 64'h0, 64'h0);
    drive(1, 0, 0, 64'h0, 64'h0);
    #1;
    check("reset_rdata", rdata2, 64'h0);
    check("reset_rvalid", {63'h0, rvalid2}, 64'h0);
    check("reset_state", {62'h0, st2}, {62'h0, ST_IDLE});
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check("idle_stall", {63'h0, stall2}, 64'h0);
    check("idle_rvalid", {63'h0, rvalid2}, 64'h0);
    check("idle_rdata", rdata2, 64'h0);

    vecs[0] = '{1'b0, 1'b1, 64'h10,  64'hDEADBEEF_CAFEF00D, 2, 1'b0, 64'h0};
    vecs[1] = '{1'b1, 1'b0, 64'h10,  64'h0,                 2, 1'b1, 64'hDEADBEEF_CAFEF00D};
    vecs[2] = '{1'b0, 1'b1, 64'h800, 64'h55,                2, 1'b0, 64'hDEADBEEF_CAFEF00D};
    vecs[3] = '{1'b1, 1'b0, 64'h0,   64'h0,                 2, 1'b1, 64'h55};
    vecs[4] = '{1'b1, 1'b1, 64'h18,  64'h7,                 2, 1'b0, 64'h55};
    vecs[5] = '{1'b1, 1'b0, 64'h18,  64'h0,                 2, 1'b1, 64'h7};
    for (int i = 0; i < 6; i++) begin
      op(2, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, stalls, rv, data, mis);
      check($sformatf("vec%0d_stalls", i), 64'(stalls), 64'(vecs[i].exp_stalls));
      check($sformatf("vec%0d_rvalid", i), {63'h0, rv}, {63'h0, vecs[i].exp_rv});
      check($sformatf("vec%0d_rdata", i), data, vecs[i].exp_rdata);
      check($sformatf("vec%0d_misalign", i), {63'h0, mis}, 64'h0);
    end

    // LATENCY=1: back-to-back held requests, one acceptance each.
    op(1, 0, 1, 64'h0, 64'h1111_2222_3333_4444, stalls, rv, data, mis);
    check("l1_st0_stalls", 64'(stalls), 64'd1);
    op(1, 0, 1, 64'h8, 64'hAAAA_BBBB_CCCC_DDDD, stalls, rv, data, mis);
    check("l1_st8_rvalid", {63'h0, rv}, 64'h0);
    op(1, 1, 0, 64'h0, 64'h0, stalls, rv, data, mis);
    check("l1_ld0_stalls", 64'(stalls), 64'd1);
    check("l1_ld0_rvalid", {63'h0, rv}, 64'h1);
    check("l1_ld0_rdata", data, 64'h1111_2222_3333_4444);
    op(1, 1, 0, 64'h8, 64'h0, stalls, rv, data, mis);
    check("l1_ld8_stalls", 64'(stalls), 64'd1);
    check("l1_ld8_rvalid", {63'h0, rv}, 64'h1);
    check("l1_ld8_rdata", data, 64'hAAAA_BBBB_CCCC_DDDD);
    @(negedge clock);
    drive(1, 0, 0, 64'h0, 64'h0);
    #1;
    check("l1_no_reaccept_rvalid", {63'h0, rvalid1}, 64'h0);
    check("l1_no_reaccept_stall", {63'h0, stall1}, 64'h0);

    // Randomized traffic on the LATENCY=2 instance against a plain memory model.
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      model_mem[i] = d;
      op(2, 0, 1, 64'(i * 8), d, stalls, rv, data, mis);
      check("prefill_rvalid", {63'h0, rv}, 64'h0);
    end
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      idx  = $urandom_range(0, 15);
`ifdef DMEM_ALIGN_CHECK_EN
      a = 64'(($urandom_range(0, 7) * 256 + idx) * 8);
`else
      a = 64'(($urandom_range(0, 7) * 256 + idx) * 8 + $urandom_range(0, 7));
`endif
      d = {$urandom, $urandom};
      is_load = (kind == 0);
      if (kind != 0) model_mem[(a / 8) % 256] = d;
      else exp_q.push_back(model_mem[(a / 8) % 256]);
      op(2, kind != 1, kind != 0, a, d, stalls, rv, data, mis);
      check("rand_stalls", 64'(stalls), 64'd2);
      check("rand_rvalid", {63'h0, rv}, {63'h0, is_load});
      if (is_load) begin
        expd = exp_q.pop_front();
        check("rand_rdata", data, expd);
      end
    end

    // Reset while a store is in BUSY, before its commit edge.
    op(2, 0, 1, 64'h20, 64'h0123_4567_89AB_CDEF, stalls, rv, data, mis);
    @(negedge clock);
    drive(2, 0, 1, 64'h20, 64'h9999_9999_9999_9999);
    @(negedge clock);
    #1;
    check("abort_pre_state", {62'h0, st2}, {62'h0, ST_BUSY});
    reset_n = 1'b0;
    drive(2, 0, 0, 64'h0, 64'h0);
    #1;
    check("abort_state", {62'h0, st2}, {62'h0, ST_IDLE});
    check("abort_stall", {63'h0, stall2}, 64'h0);
    check("abort_rdata", rdata2, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    op(2, 1, 0, 64'h20, 64'h0, stalls, rv, data, mis);
    check("abort_reload_rvalid", {63'h0, rv}, 64'h1);
    check("abort_reload_rdata", data, 64'h0123_4567_89AB_CDEF);

`ifdef DMEM_ALIGN_CHECK_EN
    op(2, 1, 0, 64'h21, 64'h0, stalls, rv, data, mis);
    check("mis_stalls", 64'(stalls), 64'd2);
    check("mis_rvalid", {63'h0, rv}, 64'h1);
    check("mis_flag", {63'h0, mis}, 64'h1);
    check("mis_rdata", data, 64'h0);
`endif

    @(negedge clock);
    drive(2, 0, 0, 64'h0, 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the pipelined LEGv8 CPU; the responding end of the CPU's load/store interface (read enable, write enable, address, store data).
- Models a multi-cycle memory: accepts one request, holds the pipeline with `stall` for a programmable latency, then commits the store or returns load data.
- Replaces the zero-latency combinational data RAM.
- Storage is DEPTH 64-bit doublewords, addressed by byte address.

Parameters:
- DEPTH, 256: number of 64-bit doublewords; power of two, at least 2.
- LATENCY, 2: cycles from acceptance to response; at least 1.

Ports:
- clock, input, 1: sole clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- req_read, input, 1: load request (readmem_en from EX/MEM).
- req_write, input, 1: store request (writemem_en from EX/MEM).
- req_addr, input, 64: byte address (ALU result).
- req_wdata, input, 64: store data.
- stall, output, 1: hold IF/ID/EX/MEM pipeline registers and PC while high.
- rdata, output, 64: load data.
- rvalid, output, 1: one-cycle pulse when rdata carries a new load result.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, counter=0, rdata=0, rvalid=0.
  - stall then follows IDLE logic.
  - Memory contents are not reset.
- FSM states: IDLE, BUSY, RESP.
- stall is combinational: (state==IDLE and (req_read or req_write)) or state==BUSY. It is low in RESP.
- IDLE:
  - If req_read or req_write, latch op, address index and wdata, and set counter=LATENCY-1.
  - Go to BUSY if LATENCY>1, else go directly to RESP with the access performed on the same edge.
  - With no request, stay in IDLE.
- BUSY:
  - Decrement counter each cycle.
  - When counter==1, perform the access on that edge and go to RESP.
  - Access: store writes mem[idx]; load registers mem[idx] into rdata.
- RESP:
  - Lasts one cycle. rvalid=1 only if the op was a load. Stall is low, so the pipeline advances on this edge.
  - Unconditionally go to IDLE. The still-present held request is not re-accepted.
- Latency:
  - Request first seen in cycle 0 gives RESP in cycle LATENCY.
  - stall is high for cycles 0..LATENCY-1.
  - rdata is valid from cycle LATENCY and holds until the next completed load.
- Addressing:
  - idx = req_addr[3 +: log2(DEPTH)].
  - Bits above idx are ignored, so addresses alias and wrap modulo DEPTH*8.
  - req_addr[2:0] is ignored unless the feature below is enabled.
- Simultaneous req_read and req_write: treated as a store. No rvalid is produced and rdata is unchanged.
- Inputs change while BUSY: ignored. The latched values are used.
- Reset mid-operation: the request is aborted. A store whose commit edge has not occurred is not written.

Optional Feature:
- DMEM_ALIGN_CHECK_EN defined:
  - Adds output `misalign` (1 bit).
  - If the latched req_addr[2:0]!=0, the access has no memory effect and rdata is loaded with 0.
  - misalign pulses high in RESP, together with rvalid if the op was a load.
  - Timing and stall are unchanged.
- Undefined: no port; low address bits are silently ignored.

Decomposition:
- Package dmem_pkg:
  - State encoding (IDLE/BUSY/RESP, 2 bits).
  - DWORD_W=64 and BYTE_OFS=3 constants.
- Sub-module dmem_array:
  - DEPTH x 64 storage with synchronous write enable and registered synchronous read.
  - Instantiated once; FSM and counter stay in dmem_responder.

Test Plan:
- Reset then idle: reset_n=0 at t=0, release. Required: rdata=0, rvalid=0, stall=0 with no requests.
- Store then load, LATENCY=2:
  - Store 0xDEADBEEF_CAFEF00D to addr 0x10. Required: stall high for 2 cycles, no rvalid.
  - Load addr 0x10. Required: rvalid in cycle 2, rdata=0xDEADBEEF_CAFEF00D.
- LATENCY=1 back-to-back: loads to 0x0 and 0x8 held on consecutive requests. Required: stall=1 in each acceptance cycle, rvalid in each following cycle, and no double acceptance in RESP.
- Wrap-around, DEPTH=256: store 0x55 to addr 0x800, load addr 0x0. Required: returns 0x55.
- Simultaneous req_read and req_write, addr 0x18, wdata 0x7. Required: store committed, no rvalid. A later load of 0x18 returns 0x7.
- Reset mid-BUSY: a store to 0x20 whose commit edge has not yet occurred is aborted by reset_n. Required: state IDLE, stall 0, location 0x20 unchanged. With DMEM_ALIGN_CHECK_EN, a load from 0x21 gives misalign=1, rdata=0.
